// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the pipeline
// memory stage (m0) and the loader/debug port (m1). Accepts one request at a
// time, drives the dataMemory strobes, and routes the response back to the
// requester that owns the transaction. Requests with both or neither enable
// set are answered with an error instead of touching memory.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; left undefined, m0 always wins (fixed priority).
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   mN_valid / mN_ready        request handshake (ready is combinational, IDLE only)
//   mN_read_enable/write_enable load / store selectors
//   mN_addr, mN_wdata          byte address and store data
//   mN_rvalid, mN_rdata,       one-cycle response pulse, load data, and
//   mN_error                   error qualifier; owner only
//   dm_*                       dataMemory strobes, addresses and write data
//   dm_read_data               dataMemory read data, valid the cycle after the read
module dmem_port_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic            m0_read_enable,
  input  logic            m0_write_enable,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_error,
  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic            m1_read_enable,
  input  logic            m1_write_enable,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_error,
  output logic            dm_read_enable,
  output logic            dm_write_enable,
  output logic [XLEN-1:0] dm_read_addr,
  output logic [XLEN-1:0] dm_write_addr,
  output logic [XLEN-1:0] dm_write_data,
  input  logic [XLEN-1:0] dm_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;

  // Latched request: owner (0 = m0, 1 = m1), enables and payload.
  logic            owner_q;
  logic            rd_en_q;
  logic            wr_en_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;

  logic            grant_sel;
  logic            accept;
  logic            illegal;
  logic            rsp_valid;
  logic            rsp_error;
  logic [XLEN-1:0] rsp_data;

  // Winner when any request is pending: 1 selects m1.
`ifdef DMEM_ARB_RR_EN
  logic rr_ptr_q;
  assign grant_sel = m1_valid & (~m0_valid | rr_ptr_q);
`else
  assign grant_sel = m1_valid & ~m0_valid;
`endif

  assign accept  = ~reset & (state_q == IDLE) & (m0_valid | m1_valid);
  assign illegal = (rd_en_q == wr_en_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request register, loaded on the accept cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      owner_q <= grant_sel;
      rd_en_q <= grant_sel ? m1_read_enable  : m0_read_enable;
      wr_en_q <= grant_sel ? m1_write_enable : m0_write_enable;
      addr_q  <= grant_sel ? m1_addr  : m0_addr;
      wdata_q <= grant_sel ? m1_wdata : m0_wdata;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Preference flips to the other requester after every grant.
  always_ff @(posedge clk) begin
    if (reset)       rr_ptr_q <= 1'b0;
    else if (accept) rr_ptr_q <= ~grant_sel;
  end
`endif

  // Next state and outputs; everything is forced to 0 while reset is high so
  // a transaction dropped mid-flight never produces a response.
  always_comb begin
    state_d         = state_q;
    m0_ready        = 1'b0;
    m1_ready        = 1'b0;
    dm_read_enable  = 1'b0;
    dm_write_enable = 1'b0;
    dm_read_addr    = '0;
    dm_write_addr   = '0;
    dm_write_data   = '0;
    rsp_valid       = 1'b0;
    rsp_error       = 1'b0;
    rsp_data        = '0;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (m0_valid | m1_valid) begin
            m0_ready = ~grant_sel;
            m1_ready = grant_sel;
            state_d  = ISSUE;
          end
        end
        ISSUE: begin
          if (illegal) begin
            rsp_valid = 1'b1;
            rsp_error = 1'b1;
            state_d   = IDLE;
          end else if (wr_en_q) begin
            dm_write_enable = 1'b1;
            dm_write_addr   = addr_q;
            dm_write_data   = wdata_q;
            rsp_valid       = 1'b1;
            state_d         = IDLE;
          end else begin
            dm_read_enable = 1'b1;
            dm_read_addr   = addr_q;
            state_d        = RDWAIT;
          end
        end
        RDWAIT: begin
          rsp_valid = 1'b1;
          rsp_data  = dm_read_data;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Response is steered to the owner; the other requester sees zeros.
    m0_rvalid = rsp_valid & ~owner_q;
    m1_rvalid = rsp_valid &  owner_q;
    m0_error  = rsp_error & ~owner_q;
    m1_error  = rsp_error &  owner_q;
    m0_rdata  = owner_q ? '0 : rsp_data;
    m1_rdata  = owner_q ? rsp_data : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: includes a behavioural dataMemory model and a
// response scoreboard (expected responses queued when a request is driven).
module tb_dmem_port_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            m0_valid, m0_ready, m0_read_enable, m0_write_enable;
  logic [XLEN-1:0] m0_addr, m0_wdata, m0_rdata;
  logic            m0_rvalid, m0_error;
  logic            m1_valid, m1_ready, m1_read_enable, m1_write_enable;
  logic [XLEN-1:0] m1_addr, m1_wdata, m1_rdata;
  logic            m1_rvalid, m1_error;
  logic            dm_read_enable, dm_write_enable;
  logic [XLEN-1:0] dm_read_addr, dm_write_addr, dm_write_data;
  logic [XLEN-1:0] dm_read_data = '0;

  dmem_port_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m0_read_enable(m0_read_enable), .m0_write_enable(m0_write_enable),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_error(m0_error),
    .m1_valid(m1_valid), .m1_ready(m1_ready),
    .m1_read_enable(m1_read_enable), .m1_write_enable(m1_write_enable),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_error(m1_error),
    .dm_read_enable(dm_read_enable), .dm_write_enable(dm_write_enable),
    .dm_read_addr(dm_read_addr), .dm_write_addr(dm_write_addr),
    .dm_write_data(dm_write_data), .dm_read_data(dm_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dataMemory model: unwritten words read back as a pattern of their address.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {16'hC0DE, a[15:0]};
  endfunction
  always @(posedge clk) begin
    if (dm_write_enable === 1'b1) mem[dm_write_addr] = dm_write_data;
    dm_read_data <= (dm_read_enable === 1'b1) ? mem_val(dm_read_addr) : 32'h0;
  end

  logic [5*XLEN+7:0] all_out;
  assign all_out = {m0_ready, m0_rvalid, m0_error, m0_rdata,
                    m1_ready, m1_rvalid, m1_error, m1_rdata,
                    dm_read_enable, dm_write_enable,
                    dm_read_addr, dm_write_addr, dm_write_data};

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } resp_t;

  resp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic clear_inputs();
    m0_valid = 0; m0_read_enable = 0; m0_write_enable = 0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 0; m1_read_enable = 0; m1_write_enable = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  // Drives one request and returns the cycle it was accepted (-1 on timeout).
  // Returns one time step after the accepting edge, i.e. inside cycle T+1.
  task automatic issue(input logic port, input logic re, input logic we,
                       input logic [31:0] a, input logic [31:0] d, output int t_acc);
    @(posedge clk); #1;
    if (port) begin
      m1_valid = 1; m1_read_enable = re; m1_write_enable = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_valid = 1; m0_read_enable = re; m0_write_enable = we; m0_addr = a; m0_wdata = d;
    end
    t_acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port ? m1_ready : m0_ready) === 1'b1) begin
        t_acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    resp_t e;
    clear_inputs();
    reset = 1'b1;
    m0_valid = 1; m0_write_enable = 1; m0_addr = 32'h4; m0_wdata = 32'h1234;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (all_out !== '0) begin
        n_err++; $display("FAIL reset_outputs[%0d]: got %h want 0", i, all_out);
      end
      @(posedge clk);
    end
    #1 reset = 1'b0;
    exp_q.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0, lat: 1});
    @(negedge clk);
    n_cmp++;
    if ({m0_ready, m1_ready} !== 2'b10) begin
      n_err++; $display("FAIL reset_first_ready: got %b want 10", {m0_ready, m1_ready});
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (m0_rvalid !== 1'b1 || dm_write_enable !== 1'b1 || dm_write_addr !== 32'h4) begin
      n_err++; $display("FAIL reset_first_store: got rvalid=%b we=%b addr=%h want 1 1 4",
                        m0_rvalid, dm_write_enable, dm_write_addr);
    end
    if (m0_rvalid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({m0_error, m0_rdata} !== {e.err, e.rdata}) begin
        n_err++; $display("FAIL reset_first_resp: got err=%b data=%h want %b %h",
                          m0_error, m0_rdata, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_store();
    resp_t e;
    int t;
    exp_q.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0, lat: 1});
    issue(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, t);
    n_cmp++;
    if (t < 0) begin n_err++; $display("FAIL store_accept: got timeout want ready"); end
    @(negedge clk);
    n_cmp++;
    if ({dm_write_enable, dm_read_enable} !== 2'b10) begin
      n_err++; $display("FAIL store_strobes: got we,re=%b want 10", {dm_write_enable, dm_read_enable});
    end
    n_cmp++;
    if (dm_write_addr !== 32'h10 || dm_write_data !== 32'hDEADBEEF || dm_read_addr !== 32'h0) begin
      n_err++; $display("FAIL store_bus: got waddr=%h wdata=%h raddr=%h want 10 deadbeef 0",
                        dm_write_addr, dm_write_data, dm_read_addr);
    end
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m1_error, m1_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL store_rvalid: got m0_rvalid=%b m1_rvalid=%b want 1 0", m0_rvalid, m1_rvalid);
    end
    if (m0_rvalid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({m0_error, m0_rdata} !== {e.err, e.rdata} || e.port !== 1'b0 || cyc != t + e.lat) begin
        n_err++; $display("FAIL store_resp: got err=%b data=%h cyc=%0d want %b %h %0d",
                          m0_error, m0_rdata, cyc, e.err, e.rdata, t + e.lat);
      end
    end
  endtask

  task automatic test_load();
    resp_t e;
    int t;
    exp_q.push_back('{port: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF, lat: 2});
    issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, t);
    n_cmp++;
    if (t < 0) begin n_err++; $display("FAIL load_accept: got timeout want ready"); end
    @(negedge clk);
    n_cmp++;
    if ({dm_read_enable, dm_write_enable, dm_read_addr, dm_write_addr, dm_write_data, m0_rvalid}
        !== {1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL load_issue: got re=%b we=%b raddr=%h waddr=%h rvalid=%b want 1 0 10 0 0",
                        dm_read_enable, dm_write_enable, dm_read_addr, dm_write_addr, m0_rvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (m0_rvalid !== 1'b1 || dm_read_enable !== 1'b0) begin
      n_err++; $display("FAIL load_rvalid: got rvalid=%b re=%b want 1 0", m0_rvalid, dm_read_enable);
    end
    n_cmp++;
    if ({m1_ready, m1_rvalid, m1_error, m1_rdata} !== '0) begin
      n_err++; $display("FAIL load_m1_quiet: got %h want 0", {m1_ready, m1_rvalid, m1_error, m1_rdata});
    end
    if (m0_rvalid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({m0_error, m0_rdata} !== {e.err, e.rdata} || cyc != t + e.lat) begin
        n_err++; $display("FAIL load_resp: got err=%b data=%h cyc=%0d want %b %h %0d",
                          m0_error, m0_rdata, cyc, e.err, e.rdata, t + e.lat);
      end
    end
  endtask

  task automatic test_illegal();
    resp_t e;
    int t;
    // m1 with both enables set
    exp_q.push_back('{port: 1'b1, err: 1'b1, rdata: 32'h0, lat: 1});
    issue(1'b1, 1'b1, 1'b1, 32'h20, 32'h5555AAAA, t);
    n_cmp++;
    if (t < 0) begin n_err++; $display("FAIL illegal_both_accept: got timeout want ready"); end
    @(negedge clk);
    n_cmp++;
    if ({dm_read_enable, dm_write_enable, m0_rvalid, m1_rvalid} !== 4'b0001) begin
      n_err++; $display("FAIL illegal_both_out: got re,we,m0rv,m1rv=%b want 0001",
                        {dm_read_enable, dm_write_enable, m0_rvalid, m1_rvalid});
    end
    if (m1_rvalid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({m1_error, m1_rdata} !== {e.err, e.rdata} || cyc != t + e.lat) begin
        n_err++; $display("FAIL illegal_both_resp: got err=%b data=%h want %b %h",
                          m1_error, m1_rdata, e.err, e.rdata);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({dm_read_enable, dm_write_enable, m1_rvalid} !== 3'b000) begin
      n_err++; $display("FAIL illegal_both_after: got %b want 000", {dm_read_enable, dm_write_enable, m1_rvalid});
    end
    // m0 with neither enable set
    exp_q.push_back('{port: 1'b0, err: 1'b1, rdata: 32'h0, lat: 1});
    issue(1'b0, 1'b0, 1'b0, 32'h30, 32'h0, t);
    @(negedge clk);
    n_cmp++;
    if ({dm_read_enable, dm_write_enable, m0_rvalid, m1_rvalid} !== 4'b0010) begin
      n_err++; $display("FAIL illegal_none_out: got re,we,m0rv,m1rv=%b want 0010",
                        {dm_read_enable, dm_write_enable, m0_rvalid, m1_rvalid});
    end
    if (m0_rvalid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({m0_error, m0_rdata} !== {e.err, e.rdata}) begin
        n_err++; $display("FAIL illegal_none_resp: got err=%b data=%h want %b %h",
                          m0_error, m0_rdata, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_arbitration();
    resp_t e;
    logic  exp_ptr;
    logic  g, exp_win, obs_port;
    logic [31:0] obs_data;
    int    n_grants;
    do_reset();
    exp_ptr  = 1'b0;
    n_grants = 0;
    m0_valid = 1; m0_read_enable = 1; m0_addr = 32'h20;
    m1_valid = 1; m1_read_enable = 1; m1_addr = 32'h40;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
        g = m1_ready;
`ifdef DMEM_ARB_RR_EN
        exp_win = exp_ptr;
`else
        exp_win = 1'b0;
`endif
        n_cmp++;
        if ({m0_ready, m1_ready} !== {~exp_win, exp_win}) begin
          n_err++; $display("FAIL arb_grant[%0d]: got m0,m1 ready=%b%b want winner m%0d",
                            n_grants, m0_ready, m1_ready, exp_win);
        end
        exp_q.push_back('{port: exp_win, err: 1'b0, rdata: mem_val(exp_win ? 32'h40 : 32'h20), lat: 2});
        exp_ptr = ~exp_win;
        n_grants++;
      end
      if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
        obs_port = m1_rvalid;
        obs_data = obs_port ? m1_rdata : m0_rdata;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL arb_resp_unexpected: got rvalid on m%0d want none", obs_port);
        end else begin
          e = exp_q.pop_front();
          if (obs_port !== e.port || obs_data !== e.rdata || (m0_rvalid & m1_rvalid) !== 1'b0
              || (m0_error | m1_error) !== 1'b0) begin
            n_err++; $display("FAIL arb_resp: got m%0d data=%h want m%0d data=%h",
                              obs_port, obs_data, e.port, e.rdata);
          end
        end
      end
    end
    clear_inputs();
    n_cmp++;
    if (n_grants != 10 || exp_q.size() != 0) begin
      n_err++; $display("FAIL arb_totals: got grants=%0d pending=%0d want 10 0", n_grants, exp_q.size());
    end
  endtask

  task automatic test_reset_rdwait();
    int t;
    issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, t);
    @(negedge clk);
    n_cmp++;
    if (dm_read_enable !== 1'b1) begin
      n_err++; $display("FAIL rdwait_issue: got re=%b want 1", dm_read_enable);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL rdwait_reset_out: got %h want 0", all_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (all_out !== '0) begin
        n_err++; $display("FAIL rdwait_after[%0d]: got %h want 0", i, all_out);
      end
    end
    // The port is usable again after the dropped transaction.
    issue(1'b1, 1'b0, 1'b1, 32'h50, 32'hCAFEF00D, t);
    @(negedge clk);
    n_cmp++;
    if (t < 0 || {m1_rvalid, m1_error, dm_write_enable, dm_write_data} !== {3'b101, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL rdwait_recover: got t=%0d rv=%b err=%b we=%b wdata=%h want store ack",
                        t, m1_rvalid, m1_error, dm_write_enable, dm_write_data);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_illegal();
    test_arbitration();
    test_reset_rdwait();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
